// File: rtl/tis_row.sv
// Row of TIS-100-style cores joined by blocking one-word channels.
// Each core fetches from its own slice of an external program ROM.
module tis_core #(
    parameter int DW = 11,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] plen,
    input  logic [15:0]   instr,
    output logic [PW-1:0] pc,
    input  logic          l_in_vld,
    input  logic [DW-1:0] l_in_data,
    input  logic          r_in_vld,
    input  logic [DW-1:0] r_in_data,
    output logic          l_take,
    output logic          r_take,
    input  logic          l_ack,
    input  logic          r_ack,
    output logic          l_out_vld,
    output logic          r_out_vld,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] acc
);
    localparam logic [2:0] L_ACC = 3'd1, L_LEFT = 3'd2, L_RIGHT = 3'd3, L_UP = 3'd4, L_DOWN = 3'd5;
    localparam logic signed [DW:0] MAXV = 999;
    localparam logic signed [DW:0] MINV = -999;

    function automatic logic [DW-1:0] sat(input logic signed [DW:0] v);
        if (v > MAXV) return MAXV[DW-1:0];
        if (v < MINV) return MINV[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic [DW:0] sx(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    logic [DW-1:0] acc_q, acc_d, bak_q, bak_d, hold_q, hold_d, wr_data_q, wr_data_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [2:0]    wr_dst_q, wr_dst_d;
    logic          hold_vld_q, hold_vld_d, wr_vld_q, wr_vld_d, wr_done_q, wr_done_d;

    logic          is_movi, is_mov, use_imm, src_port, dst_port, hold_phase, src_ok, take, busy, ack, taken;
    logic [2:0]    op, src, dst;
    logic [DW-1:0] src_val, imm_c;
    logic [PW-1:0] pc_inc;
    logic signed [DW:0] sum, jro, plen_x;

    always_comb begin
        is_movi    = instr[15];
        op         = instr[14:12];
        use_imm    = instr[11];
        src        = instr[2:0];
        dst        = is_movi ? instr[14:12] : instr[5:3];
        imm_c      = sat(sx(instr[10:0]));
        is_mov     = is_movi || op == 3'd4;
        src_port   = !is_movi && !use_imm && (op inside {3'd1, 3'd2, 3'd3, 3'd4})
                     && (src inside {L_LEFT, L_RIGHT, L_UP, L_DOWN});
        dst_port   = is_mov && (dst inside {L_LEFT, L_RIGHT, L_UP, L_DOWN});
        hold_phase = src_port && dst_port && hold_vld_q;
        src_ok     = 1'b1;
        src_val    = '0;
        if (is_movi || use_imm) src_val = imm_c;
        else if (src == L_ACC)  src_val = acc_q;
        if (hold_phase) begin
            src_val = hold_q;
        end else if (src_port) begin
            // UP/DOWN never see a valid word, so they stall forever.
            src_ok  = (src == L_LEFT && l_in_vld) || (src == L_RIGHT && r_in_vld);
            src_val = (src == L_LEFT) ? l_in_data : r_in_data;
        end
        busy   = plen == '0 || wr_vld_q || wr_done_q;
        take   = src_port && !hold_phase && src_ok && !busy;
        l_take = take && src == L_LEFT;
        r_take = take && src == L_RIGHT;
        ack    = (wr_dst_q == L_LEFT && l_ack) || (wr_dst_q == L_RIGHT && r_ack);
        pc_inc = ({1'b0, pc_q} + 5'd1 >= {1'b0, plen}) ? '0 : pc_q + PW'(1);
        sum    = (op == 3'd2) ? $signed(sx(acc_q)) - $signed(sx(src_val))
                              : $signed(sx(acc_q)) + $signed(sx(src_val));
        plen_x = $signed({{(DW+1-PW){1'b0}}, plen});
        jro    = $signed({{(DW+1-PW){1'b0}}, pc_q}) + $signed(sx(src_val));
        case (instr[6:4])
            3'd0:    taken = 1'b1;
            3'd1:    taken = acc_q == '0;
            3'd2:    taken = acc_q != '0;
            3'd3:    taken = !acc_q[DW-1] && acc_q != '0;
            3'd4:    taken = acc_q[DW-1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        bak_d      = bak_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        wr_vld_d   = wr_vld_q;
        wr_dst_d   = wr_dst_q;
        wr_data_d  = wr_data_q;
        wr_done_d  = wr_done_q;
        if (plen == '0) begin
            pc_d = '0;
        end else if (wr_done_q) begin
            wr_done_d = 1'b0;
            pc_d      = pc_inc;
        end else if (wr_vld_q) begin
            if (ack) begin
                wr_vld_d  = 1'b0;
                wr_done_d = 1'b1;
            end
        end else if (src_ok) begin
            if (is_mov) begin
                if (dst_port && src_port && !hold_phase) begin
                    hold_d     = src_val;
                    hold_vld_d = 1'b1;
                end else if (dst_port) begin
                    hold_vld_d = 1'b0;
                    wr_vld_d   = 1'b1;
                    wr_dst_d   = dst;
                    wr_data_d  = src_val;
                end else begin
                    if (dst == L_ACC) acc_d = src_val;
                    pc_d = pc_inc;
                end
            end else begin
                pc_d = pc_inc;
                case (op)
                    3'd0: case (instr[1:0])
                        2'd1:    begin acc_d = bak_q; bak_d = acc_q; end
                        2'd2:    bak_d = acc_q;
                        2'd3:    acc_d = sat(-$signed(sx(acc_q)));
                        default: ;
                    endcase
                    3'd1, 3'd2: acc_d = sat(sum);
                    3'd3: begin
                        if (jro < 0)            pc_d = '0;
                        else if (jro >= plen_x) pc_d = plen - PW'(1);
                        else                    pc_d = jro[PW-1:0];
                    end
                    3'd5: if (taken) pc_d = (instr[3:0] >= plen) ? '0 : instr[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            bak_q      <= '0;
            pc_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_dst_q   <= '0;
            wr_data_q  <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            bak_q      <= bak_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            wr_vld_q   <= wr_vld_d;
            wr_dst_q   <= wr_dst_d;
            wr_data_q  <= wr_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign pc        = pc_q;
    assign acc       = acc_q;
    assign out_data  = wr_data_q;
    assign l_out_vld = wr_vld_q && wr_dst_q == L_LEFT;
    assign r_out_vld = wr_vld_q && wr_dst_q == L_RIGHT;
endmodule

module tis_row #(
    parameter int NCORES = 4,
    parameter int PMAX   = 15,
    parameter int DW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    pLength [0:NCORES-1],
    input  logic [15:0]   prog    [0:NCORES*PMAX-1],
    output logic [DW-1:0] acc     [0:NCORES-1]
);
    logic [NCORES-1:0]         l_out_vld, r_out_vld, l_take, r_take;
    logic [NCORES-1:0][DW-1:0] out_data, acc_w;
    logic [NCORES-1:0][3:0]    pc;
    logic [NCORES-1:0][15:0]   instr;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        logic          l_in_vld, r_in_vld, l_ack, r_ack;
        logic [DW-1:0] l_in_data, r_in_data;

        // End-of-row ports have no partner, so they never see valid or ack.
        if (i == 0) begin : g_lend
            assign l_in_vld  = 1'b0;
            assign l_in_data = '0;
            assign l_ack     = 1'b0;
        end else begin : g_lnb
            assign l_in_vld  = r_out_vld[i-1];
            assign l_in_data = out_data[i-1];
            assign l_ack     = r_take[i-1];
        end
        if (i == NCORES-1) begin : g_rend
            assign r_in_vld  = 1'b0;
            assign r_in_data = '0;
            assign r_ack     = 1'b0;
        end else begin : g_rnb
            assign r_in_vld  = l_out_vld[i+1];
            assign r_in_data = out_data[i+1];
            assign r_ack     = l_take[i+1];
        end

        assign instr[i] = (pc[i] < 4'(PMAX)) ? prog[i*PMAX + int'(pc[i])] : 16'h0000;
        assign acc[i]   = acc_w[i];

        tis_core #(.DW(DW), .PW(4)) u_core (
            .clk       (clk),
            .rst       (rst),
            .plen      (pLength[i]),
            .instr     (instr[i]),
            .pc        (pc[i]),
            .l_in_vld  (l_in_vld),
            .l_in_data (l_in_data),
            .r_in_vld  (r_in_vld),
            .r_in_data (r_in_data),
            .l_take    (l_take[i]),
            .r_take    (r_take[i]),
            .l_ack     (l_ack),
            .r_ack     (r_ack),
            .l_out_vld (l_out_vld[i]),
            .r_out_vld (r_out_vld[i]),
            .out_data  (out_data[i]),
            .acc       (acc_w[i])
        );
    end
endmodule

// File: tb/tb_tis_row.sv
// Directed bench for tis_row: arithmetic, saturation, jumps, channels, blocking, reset.
module tb_tis_row;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pLength [0:3];
    logic [15:0] prog    [0:59];
    logic [10:0] acc     [0:3];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tis_row dut (.clk(clk), .rst(rst), .pLength(pLength), .prog(prog), .acc(acc));

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 60; i++) prog[i] = 16'h0000;
        for (int i = 0; i < 4; i++) pLength[i] = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    int sat_exp [5] = '{999, 999, -999, -999, -999};
    int jmp_exp [8] = '{1, 1, -1, 0, 0, 100, -100, -99};

    initial begin
        clear_prog();
        step(1);

        // ADD 5 in a one-slot loop, then saturation
        prog[0] = 16'h1805; pLength[0] = 4'd1;
        do_reset();
        check("reset_acc0", acc[0], 11'd0);
        step(1); check("add5_1", acc[0], 11'd5);
        step(1); check("add5_2", acc[0], 11'd10);
        step(1); check("add5_3", acc[0], 11'd15);
        step(200); check("add5_sat", acc[0], 11'd999);
        step(1); check("add5_hold", acc[0], 11'd999);
        for (int i = 1; i < 4; i++) check($sformatf("idle_acc%0d", i), acc[i], 11'd0);

        // Transfer core0 -> core1
        clear_prog();
        prog[0] = 16'hB007; prog[15] = 16'h400A; pLength[0] = 4'd1; pLength[1] = 4'd1;
        do_reset();
        for (int k = 0; k < 3 && acc[1] !== 11'd7; k++) step(1);
        check("xfer_latency", acc[1], 11'd7);
        for (int k = 0; k < 3; k++) begin
            step(10);
            check("xfer_acc1", acc[1], 11'd7);
            check("xfer_acc0", acc[0], 11'd0);
        end

        // Blocked read on unconnected LEFT; ADD 1 behind it must never run
        clear_prog();
        prog[0] = 16'h400A; prog[1] = 16'h1801; pLength[0] = 4'd2;
        do_reset();
        step(100);
        check("block_acc0", acc[0], 11'd0);
        rst = 1'b1;
        prog[0] = 16'h1805; pLength[0] = 4'd1;
        step(1);
        check("block_rst", acc[0], 11'd0);
        rst = 1'b0;
        step(1);
        check("block_after_rst", acc[0], 11'd5);

        // Saturation, NEG, SAV, SWP
        clear_prog();
        prog[0] = 16'h1BE7; prog[1] = 16'h1801; prog[2] = 16'h0003;
        prog[3] = 16'h0002; prog[4] = 16'h0001; pLength[0] = 4'd5;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("sat_seq%0d", k), acc[0], 11'(sat_exp[k]));
        end

        // JGZ over ADD 100, loop continues from PC 0
        clear_prog();
        prog[0] = 16'h1801; prog[1] = 16'h5033; prog[2] = 16'h1864;
        prog[3] = 16'h0003; pLength[0] = 4'd4;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("jmp_seq%0d", k), acc[0], 11'(jmp_exp[k]));
        end

        // Reset while core0 is stalled on a write: nothing may leak through
        clear_prog();
        prog[0] = 16'hB007; pLength[0] = 4'd1;
        do_reset();
        step(5);
        rst = 1'b1;
        pLength[0] = 4'd0; pLength[1] = 4'd1; prog[15] = 16'h400A;
        step(1);
        for (int i = 0; i < 4; i++) check($sformatf("midrst_acc%0d", i), acc[i], 11'd0);
        rst = 1'b0;
        step(10);
        check("midrst_no_leak", acc[1], 11'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
